// File: rtl/proc_threshold_ctrl.sv
// Threshold register file, frame-synchronous commit, coordinate tracking and per-frame red bounding box.
// Optional PROC_CTRL_IRQ_EN adds a sticky frame interrupt on irq, visible and cleared through STATUS[31].
module proc_threshold_ctrl #(
  parameter int IMAGE_W  = 640,
  parameter int IMAGE_H  = 480,
  parameter int PIPE_LAT = 6,
  parameter int CW       = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  input  logic        s_read,
  output logic [31:0] s_readdata,
  input  logic        sop,
  input  logic        packet_video,
  input  logic        in_valid,
  input  logic        red_sector,
  output logic [8:0]  hue_lo,
  output logic [8:0]  hue_hi,
  output logic [7:0]  sat_min,
  output logic [7:0]  val_lo,
  output logic [7:0]  val_hi,
  output logic        proc_en,
`ifdef PROC_CTRL_IRQ_EN
  output logic        irq,
`endif
  output logic        frame_done
);

  localparam logic [CW-1:0] X_LAST  = CW'(IMAGE_W - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(IMAGE_H - 1);
  localparam logic [19:0]   CNT_MAX = '1;

  typedef enum logic [1:0] {WAIT_SOP, ACTIVE, LATCH} state_t;

  logic [8:0] stg_hue_lo, stg_hue_hi;
  logic [7:0] stg_sat, stg_val_lo, stg_val_hi;
  logic       stg_en;
  logic       commit_pending;

  logic vsop;
  logic wr_hue, wr_sv, wr_ctrl;
  logic commit_now;

  assign vsop    = in_valid & sop & packet_video;
  assign wr_hue  = s_write && (s_address == 3'd0);
  assign wr_sv   = s_write && (s_address == 3'd1);
  assign wr_ctrl = s_write && (s_address == 3'd2);
  // A commit request written on the sop cycle itself is honoured immediately.
  assign commit_now = vsop & (commit_pending | (wr_ctrl & s_writedata[1]));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_hue_lo     <= 9'd5;
      stg_hue_hi     <= 9'd15;
      stg_sat        <= 8'd40;
      stg_val_lo     <= 8'd20;
      stg_val_hi     <= 8'd200;
      stg_en         <= 1'b1;
      commit_pending <= 1'b0;
      hue_lo         <= 9'd5;
      hue_hi         <= 9'd15;
      sat_min        <= 8'd40;
      val_lo         <= 8'd20;
      val_hi         <= 8'd200;
      proc_en        <= 1'b1;
    end else begin
      if (wr_hue) begin
        stg_hue_lo <= s_writedata[8:0];
        stg_hue_hi <= s_writedata[24:16];
      end
      if (wr_sv) begin
        stg_sat    <= s_writedata[7:0];
        stg_val_lo <= s_writedata[15:8];
        stg_val_hi <= s_writedata[23:16];
      end
      if (wr_ctrl) begin
        stg_en <= s_writedata[0];
      end
      if (commit_now) begin
        hue_lo         <= stg_hue_lo;
        hue_hi         <= stg_hue_hi;
        sat_min        <= stg_sat;
        val_lo         <= stg_val_lo;
        val_hi         <= stg_val_hi;
        proc_en        <= stg_en;
        commit_pending <= 1'b0;
      end else if (wr_ctrl && s_writedata[1]) begin
        commit_pending <= 1'b1;
      end
    end
  end

  // Coordinates of the pixel being accepted this cycle; cnt_* holds the previous one.
  logic [CW-1:0] cnt_x, cnt_y;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_valid, pix_last;

  always_comb begin
    pix_valid = in_valid & packet_video;
    pix_x     = '0;
    pix_y     = '0;
    if (!sop) begin
      if (cnt_x == X_LAST) begin
        pix_x = '0;
        pix_y = (cnt_y == Y_LAST) ? cnt_y : cnt_y + CW'(1);
      end else begin
        pix_x = cnt_x + CW'(1);
        pix_y = cnt_y;
      end
    end
    pix_last = (pix_x == X_LAST) && (pix_y == Y_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_x <= '0;
      cnt_y <= '0;
    end else if (pix_valid) begin
      cnt_x <= pix_x;
      cnt_y <= pix_y;
    end
  end

  logic [PIPE_LAT-1:0]         dl_valid, dl_last;
  logic [PIPE_LAT-1:0][CW-1:0] dl_x, dl_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_valid <= '0;
      dl_last  <= '0;
      dl_x     <= '0;
      dl_y     <= '0;
    end else begin
      dl_valid <= {dl_valid[PIPE_LAT-2:0], pix_valid};
      dl_last  <= {dl_last[PIPE_LAT-2:0], pix_last};
      dl_x     <= {dl_x[PIPE_LAT-2:0], pix_x};
      dl_y     <= {dl_y[PIPE_LAT-2:0], pix_y};
    end
  end

  logic          d_valid, d_last;
  logic [CW-1:0] d_x, d_y;

  assign d_valid = dl_valid[PIPE_LAT-1];
  assign d_last  = dl_last[PIPE_LAT-1];
  assign d_x     = dl_x[PIPE_LAT-1];
  assign d_y     = dl_y[PIPE_LAT-1];

  state_t        state;
  logic [CW-1:0] acc_min_x, acc_min_y, acc_max_x, acc_max_y;
  logic [19:0]   acc_count;
  logic [CW-1:0] res_min_x, res_min_y, res_max_x, res_max_y;
  logic [19:0]   res_count;
  logic [15:0]   frame_count;
  logic          acc_clr, acc_upd;

  // A video sop outside LATCH either starts or aborts a frame; both start from empty accumulators.
  assign acc_clr = vsop || (state == LATCH);
  assign acc_upd = (state == ACTIVE) && d_valid && red_sector;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_min_x <= '1;
      acc_min_y <= '1;
      acc_max_x <= '0;
      acc_max_y <= '0;
      acc_count <= '0;
    end else if (acc_clr) begin
      acc_min_x <= '1;
      acc_min_y <= '1;
      acc_max_x <= '0;
      acc_max_y <= '0;
      acc_count <= '0;
    end else if (acc_upd) begin
      if (d_x < acc_min_x) acc_min_x <= d_x;
      if (d_y < acc_min_y) acc_min_y <= d_y;
      if (d_x > acc_max_x) acc_max_x <= d_x;
      if (d_y > acc_max_y) acc_max_y <= d_y;
      if (acc_count != CNT_MAX) acc_count <= acc_count + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= WAIT_SOP;
      res_min_x   <= '1;
      res_min_y   <= '1;
      res_max_x   <= '0;
      res_max_y   <= '0;
      res_count   <= '0;
      frame_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        WAIT_SOP: begin
          if (vsop) state <= ACTIVE;
        end
        ACTIVE: begin
          if (!vsop && d_valid && d_last) state <= LATCH;
        end
        LATCH: begin
          res_min_x   <= acc_min_x;
          res_min_y   <= acc_min_y;
          res_max_x   <= acc_max_x;
          res_max_y   <= acc_max_y;
          res_count   <= acc_count;
          frame_count <= frame_count + 16'd1;
          frame_done  <= 1'b1;
          state       <= WAIT_SOP;
        end
        default: state <= WAIT_SOP;
      endcase
    end
  end

  logic irq_bit;

`ifdef PROC_CTRL_IRQ_EN
  logic wr_status;
  assign wr_status = s_write && (s_address == 3'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else if (state == LATCH) begin
      irq <= 1'b1;
    end else if (wr_status && s_writedata[31]) begin
      irq <= 1'b0;
    end
  end

  assign irq_bit = irq;
`else
  assign irq_bit = 1'b0;
`endif

  logic unused_wdata;
  assign unused_wdata = ^s_writedata[31:25];

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    case (s_address)
      3'd0: rd_mux = {7'd0, stg_hue_hi, 7'd0, stg_hue_lo};
      3'd1: rd_mux = {8'd0, stg_val_hi, stg_val_lo, stg_sat};
      3'd2: rd_mux = {30'd0, commit_pending, stg_en};
      3'd3: rd_mux = {irq_bit, 14'd0, commit_pending, frame_count};
      3'd4: begin
        rd_mux[CW-1:0]     = res_min_x;
        rd_mux[16+CW-1:16] = res_min_y;
      end
      3'd5: begin
        rd_mux[CW-1:0]     = res_max_x;
        rd_mux[16+CW-1:16] = res_max_y;
      end
      3'd6: rd_mux[19:0] = res_count;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_readdata <= '0;
    end else if (s_read) begin
      s_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_proc_threshold_ctrl.sv
// Scoreboard bench for proc_threshold_ctrl on a reduced 120x60 frame; expected register reads are queued
// with the stimulus and popped as the reads return.
module tb_proc_threshold_ctrl;

  localparam int W  = 120;
  localparam int H  = 60;
  localparam int PL = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  s_address;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_read;
  logic [31:0] s_readdata;
  logic        sop, packet_video, in_valid, red_sector;
  logic [8:0]  hue_lo, hue_hi;
  logic [7:0]  sat_min, val_lo, val_hi;
  logic        proc_en, frame_done;

`ifdef PROC_CTRL_IRQ_EN
  logic irq;
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  proc_threshold_ctrl #(
    .IMAGE_W (W),
    .IMAGE_H (H),
    .PIPE_LAT(PL),
    .CW      (11)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .s_address   (s_address),
    .s_write     (s_write),
    .s_writedata (s_writedata),
    .s_read      (s_read),
    .s_readdata  (s_readdata),
    .sop         (sop),
    .packet_video(packet_video),
    .in_valid    (in_valid),
    .red_sector  (red_sector),
    .hue_lo      (hue_lo),
    .hue_hi      (hue_hi),
    .sat_min     (sat_min),
    .val_lo      (val_lo),
    .val_hi      (val_hi),
    .proc_en     (proc_en),
`ifdef PROC_CTRL_IRQ_EN
    .irq         (irq),
`endif
    .frame_done  (frame_done)
  );

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          fd_count = 0;
  logic [PL:0] hist;
  logic        red_now;

  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  // Pipeline stand-in: red_sector presents the classification of the pixel accepted PL cycles earlier.
  task automatic cycle();
    hist       = {hist[PL-1:0], red_now & in_valid};
    red_sector = hist[PL];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_pix(input logic s, input logic vid, input logic red);
    in_valid = 1'b1; sop = s; packet_video = vid; red_now = red;
    cycle();
    in_valid = 1'b0; sop = 1'b0; packet_video = 1'b0; red_now = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    s_write = 1'b1; s_address = a; s_writedata = d;
    cycle();
    s_write = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    s_read = 1'b1; s_address = a;
    cycle();
    s_read = 1'b0;
    d = s_readdata;
  endtask

  function automatic logic red_fn(input int mode, input int x, input int y);
    case (mode)
      1:       return (x >= 100 && x <= 109 && y >= 50 && y <= 54);
      2:       return (x == 3 && y == 4);
      3:       return (x < 50);
      default: return 1'b0;
    endcase
  endfunction

  // One idle beat per line; on line 52 a red non-video beat and a non-video sop are slipped in.
  task automatic stream_frame(input bit with_sop, input int mode, input int rows);
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == 52 && x == 105) begin
          send_pix(1'b0, 1'b0, 1'b1);
          send_pix(1'b1, 1'b0, 1'b0);
        end
        send_pix(with_sop && x == 0 && y == 0, 1'b1, red_fn(mode, x, y));
      end
      idle(1);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    exp_t        e;
    reset_n = 1'b0; s_address = '0; s_write = 1'b0; s_writedata = '0; s_read = 1'b0;
    sop = 1'b0; packet_video = 1'b0; in_valid = 1'b0; red_sector = 1'b0;
    red_now = 1'b0; hist = '0;
    idle(3);
    n_cmp++;
    if ({s_readdata, frame_done} !== 33'd0) begin
      n_err++; $display("FAIL reset_rd_fd got=%h/%b exp=0/0", s_readdata, frame_done);
    end
    n_cmp++;
    if ({hue_lo, hue_hi, sat_min, val_lo, val_hi, proc_en} !== {9'd5, 9'd15, 8'd40, 8'd20, 8'd200, 1'b1}) begin
      n_err++;
      $display("FAIL reset_active got=%0d/%0d/%0d/%0d/%0d/%b exp=5/15/40/20/200/1",
               hue_lo, hue_hi, sat_min, val_lo, val_hi, proc_en);
    end
    reset_n = 1'b1;
    idle(2);
    exp_q.push_back(exp_t'{3'd0, 32'h000F0005});
    exp_q.push_back(exp_t'{3'd1, 32'h00C81428});
    exp_q.push_back(exp_t'{3'd2, 32'h00000001});
    exp_q.push_back(exp_t'{3'd3, 32'h00000000});
    exp_q.push_back(exp_t'{3'd4, 32'h07FF07FF});
    exp_q.push_back(exp_t'{3'd5, 32'h00000000});
    exp_q.push_back(exp_t'{3'd6, 32'h00000000});
    exp_q.push_back(exp_t'{3'd7, 32'h00000000});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL reset_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
  endtask

  task automatic test_commit();
    logic [31:0] d;
    exp_t        e;
    reg_write(3'd0, 32'h001E000A);
    repeat (2) begin
      send_pix(1'b1, 1'b1, 1'b0);
      repeat (7) send_pix(1'b0, 1'b1, 1'b0);
      idle(2);
    end
    n_cmp++;
    if ({hue_lo, hue_hi} !== {9'd5, 9'd15}) begin
      n_err++; $display("FAIL hue_uncommitted got=%0d/%0d exp=5/15", hue_lo, hue_hi);
    end
    reg_write(3'd2, 32'h3);
    n_cmp++;
    if ({hue_lo, hue_hi} !== {9'd5, 9'd15}) begin
      n_err++; $display("FAIL hue_pending_no_sop got=%0d/%0d exp=5/15", hue_lo, hue_hi);
    end
    exp_q.push_back(exp_t'{3'd2, 32'h00000003});
    exp_q.push_back(exp_t'{3'd0, 32'h001E000A});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL staged_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
    send_pix(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({hue_lo, hue_hi} !== {9'd10, 9'd30}) begin
      n_err++; $display("FAIL hue_commit got=%0d/%0d exp=10/30", hue_lo, hue_hi);
    end
    repeat (7) send_pix(1'b0, 1'b1, 1'b0);
    idle(2);
    // Commit request written on the sop cycle itself.
    reg_write(3'd0, 32'h00140007);
    s_write = 1'b1; s_address = 3'd2; s_writedata = 32'h3;
    in_valid = 1'b1; sop = 1'b1; packet_video = 1'b1;
    cycle();
    s_write = 1'b0; in_valid = 1'b0; sop = 1'b0; packet_video = 1'b0;
    n_cmp++;
    if ({hue_lo, hue_hi} !== {9'd7, 9'd20}) begin
      n_err++; $display("FAIL hue_same_cycle_commit got=%0d/%0d exp=7/20", hue_lo, hue_hi);
    end
    // A staged write on the commit cycle must not reach the active set.
    reg_write(3'd2, 32'h3);
    s_write = 1'b1; s_address = 3'd1; s_writedata = 32'h00FF1020;
    in_valid = 1'b1; sop = 1'b1; packet_video = 1'b1;
    cycle();
    s_write = 1'b0; in_valid = 1'b0; sop = 1'b0; packet_video = 1'b0;
    n_cmp++;
    if ({sat_min, val_lo, val_hi} !== {8'd40, 8'd20, 8'd200}) begin
      n_err++; $display("FAIL sv_excluded got=%0d/%0d/%0d exp=40/20/200", sat_min, val_lo, val_hi);
    end
    exp_q.push_back(exp_t'{3'd2, 32'h00000001});
    exp_q.push_back(exp_t'{3'd1, 32'h00FF1020});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL commit_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
    reg_write(3'd2, 32'h2);
    send_pix(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({proc_en, sat_min, val_lo, val_hi} !== {1'b0, 8'h20, 8'h10, 8'hFF}) begin
      n_err++; $display("FAIL en_off got=%b/%h/%h/%h exp=0/20/10/ff", proc_en, sat_min, val_lo, val_hi);
    end
    reg_write(3'd2, 32'h3);
    send_pix(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (proc_en !== 1'b1) begin n_err++; $display("FAIL en_on got=%b exp=1", proc_en); end
    idle(2);
    reg_write(3'd4, 32'hFFFFFFFF);
    reg_write(3'd3, 32'h0000FFFF);
    reg_write(3'd7, 32'hFFFFFFFF);
    exp_q.push_back(exp_t'{3'd4, 32'h07FF07FF});
    exp_q.push_back(exp_t'{3'd3, 32'h00000000});
    exp_q.push_back(exp_t'{3'd7, 32'h00000000});
    exp_q.push_back(exp_t'{3'd2, 32'h00000001});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL ro_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
  endtask

  task automatic test_frame_box();
    logic [31:0] d;
    exp_t        e;
    int          fd0;
    exp_q.push_back(exp_t'{3'd4, 32'h00320064});
    exp_q.push_back(exp_t'{3'd5, 32'h0036006D});
    exp_q.push_back(exp_t'{3'd6, 32'd50});
    exp_q.push_back(exp_t'{3'd3, {IRQ_ON, 15'd0, 16'd1}});
    fd0 = fd_count;
    stream_frame(1'b1, 1, H);
    idle(12);
    n_cmp++;
    if (fd_count - fd0 != 1) begin n_err++; $display("FAIL box_frame_done got=%0d exp=1", fd_count - fd0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL box_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
  endtask

  task automatic test_frame_empty();
    logic [31:0] d;
    exp_t        e;
    int          fd0;
    fd0 = fd_count;
    stream_frame(1'b1, 0, H);
    // Five more idles land the next read on the LATCH cycle, which still returns the previous result.
    idle(5);
    exp_q.push_back(exp_t'{3'd6, 32'd50});
    e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
    if (d !== e.val) begin n_err++; $display("FAIL latch_cycle_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    idle(6);
    n_cmp++;
    if (fd_count - fd0 != 1) begin n_err++; $display("FAIL empty_frame_done got=%0d exp=1", fd_count - fd0); end
    exp_q.push_back(exp_t'{3'd4, 32'h07FF07FF});
    exp_q.push_back(exp_t'{3'd5, 32'h00000000});
    exp_q.push_back(exp_t'{3'd6, 32'h00000000});
    exp_q.push_back(exp_t'{3'd3, {IRQ_ON, 15'd0, 16'd2}});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL empty_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    exp_t        e;
    int          fd0;
    exp_q.push_back(exp_t'{3'd4, 32'h00040003});
    exp_q.push_back(exp_t'{3'd5, 32'h00040003});
    exp_q.push_back(exp_t'{3'd6, 32'd1});
    exp_q.push_back(exp_t'{3'd3, {IRQ_ON, 15'd0, 16'd3}});
    fd0 = fd_count;
    stream_frame(1'b1, 3, 30);
    stream_frame(1'b1, 2, H);
    idle(12);
    n_cmp++;
    if (fd_count - fd0 != 1) begin n_err++; $display("FAIL abort_frame_done got=%0d exp=1", fd_count - fd0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL abort_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
  endtask

`ifdef PROC_CTRL_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    exp_t        e;
    int          fd0;
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_sticky got=%b exp=1", irq); end
    reg_write(3'd3, 32'h80000000);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got=%b exp=0", irq); end
    exp_q.push_back(exp_t'{3'd3, 32'h00000003});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL irq_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
    fd0 = fd_count;
    stream_frame(1'b1, 0, H);
    idle(5);
    // Clear request on the LATCH cycle loses to the set.
    reg_write(3'd3, 32'h80000000);
    idle(2);
    n_cmp++;
    if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set_wins got=%b exp=1", irq); end
    n_cmp++;
    if (fd_count - fd0 != 1) begin n_err++; $display("FAIL irq_frame_done got=%0d exp=1", fd_count - fd0); end
    exp_q.push_back(exp_t'{3'd3, 32'h80000004});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL irq_status_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
    reg_write(3'd3, 32'h80000000);
    n_cmp++;
    if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear2 got=%b exp=0", irq); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] d;
    exp_t        e;
    int          fd0;
    stream_frame(1'b1, 3, 20);
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if ({hue_lo, hue_hi, proc_en, s_readdata} !== {9'd5, 9'd15, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL async_reset got=%0d/%0d/%b/%h exp=5/15/1/0", hue_lo, hue_hi, proc_en, s_readdata);
    end
    cycle();
    reset_n = 1'b1;
    fd0 = fd_count;
    stream_frame(1'b0, 1, H);
    idle(12);
    n_cmp++;
    if (fd_count - fd0 != 0) begin n_err++; $display("FAIL nosop_frame_done got=%0d exp=0", fd_count - fd0); end
    exp_q.push_back(exp_t'{3'd3, 32'h00000000});
    exp_q.push_back(exp_t'{3'd4, 32'h07FF07FF});
    exp_q.push_back(exp_t'{3'd6, 32'h00000000});
    exp_q.push_back(exp_t'{3'd0, 32'h000F0005});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); reg_read(e.addr, d); n_cmp++;
      if (d !== e.val) begin n_err++; $display("FAIL reset_mid_rd addr=%0d got=%h exp=%h", e.addr, d, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_frame_box();
    test_frame_empty();
    test_abort();
`ifdef PROC_CTRL_IRQ_EN
    test_irq();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_threshold_ctrl.md
Name: proc_threshold_ctrl

Overview:
- Control and configuration block for the red-sector pixel processing pipeline (blur, HSV, red classification).
- Holds the HSV threshold registers in an Avalon-MM register file and applies them to the pipeline only at frame boundaries, via shadow registers.
- Tracks pixel coordinates from the video stream and aligns them with the pipeline's red_sector output using a delay line.
- Accumulates a per-frame red bounding box and pixel count, and latches the results at end of frame for software to read.

Parameters:
- IMAGE_W, 640, active pixels per line.
- IMAGE_H, 480, active lines per frame.
- PIPE_LAT, 6, cycles between pixel accept at the pipeline input and the matching red_sector.
- CW, 11, coordinate counter width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_address  in  3  register word address.
- s_write  in  1  register write strobe.
- s_writedata  in  32  write data.
- s_read  in  1  register read strobe.
- s_readdata  out  32  read data; valid 1 cycle after s_read.
- sop  in  1  start of packet, qualified by in_valid.
- packet_video  in  1  current packet is video.
- in_valid  in  1  pixel accepted at pipeline input this cycle.
- red_sector  in  1  pipeline classification, PIPE_LAT cycles after accept.
- hue_lo, hue_hi  out  9 each  active hue window (exclusive bounds).
- sat_min  out  8  active saturation threshold.
- val_lo, val_hi  out  8 each  active value window.
- proc_en  out  1  1 = colour highlight on; 0 = pipeline outputs grey only.
- frame_done  out  1  one-cycle pulse when frame results are latched.

Behaviour:
- Reset values:
  - Staged and active thresholds: hue 5/15, sat_min 40, val 20/200, proc_en 1.
  - s_readdata 0, frame_done 0, frame counter 0.
  - Results: bbox min = all-ones, bbox max = 0, count 0.
  - FSM in WAIT_SOP.
- Register map (word addresses):
  - 0 HUE rw: [8:0] hue_lo, [24:16] hue_hi.
  - 1 SV rw: [7:0] sat_min, [15:8] val_lo, [23:16] val_hi.
  - 2 CTRL rw: [0] enable, [1] commit (write 1 sets commit_pending; reads back commit_pending).
  - 3 STATUS ro: [15:0] frame_count, [16] commit_pending.
  - 4 BBOX_MIN ro: [10:0] x, [26:16] y.
  - 5 BBOX_MAX ro: same layout as BBOX_MIN.
  - 6 PIXCOUNT ro: [19:0] red pixel count.
  - Other addresses read 0; writes to ro or unmapped addresses are ignored.
- Register writes land only in staged registers.
- Commit to active outputs:
  - Occurs on the cycle in_valid & sop & packet_video while commit_pending = 1; outputs update the next cycle and commit_pending clears.
  - A commit write in the same cycle as a commit sop still commits; pending stays 0.
  - Staged writes in that cycle are not included in the commit.
- Input coordinate counter, on in_valid & packet_video:
  - sop → x = 0, y = 0.
  - Otherwise x + 1, wrapping at IMAGE_W-1 to 0 with y + 1.
  - y saturates at IMAGE_H-1.
  - in_valid with packet_video = 0 is ignored.
- Delay line: PIPE_LAT-stage shift of {valid, x, y, last}, where last = (x == IMAGE_W-1 && y == IMAGE_H-1). It advances every clk, not gated by in_valid.
- FSM:
  - WAIT_SOP → ACTIVE on a video sop.
  - ACTIVE → LATCH when a delayed valid with last = 1 exits the delay line.
  - LATCH → WAIT_SOP after 1 cycle.
  - A video sop in ACTIVE aborts the frame: accumulators clear, no latch, no frame_done, and the FSM stays ACTIVE.
- Accumulation (ACTIVE only): on a delayed valid with red_sector = 1, update min/max x/y and increment count. Count saturates at 2^20-1.
- LATCH:
  - Copy accumulators to result registers.
  - Pulse frame_done.
  - frame_count + 1, wrapping at 65535 to 0.
  - Clear accumulators.
- A frame with no red pixels latches min = all-ones, max = 0, count = 0.
- The result registers change only in LATCH. A read in the same cycle as LATCH returns the old value.
- Reset asserted mid-frame: everything returns to reset values asynchronously. After release, no accumulation occurs until the next video sop.

Optional Feature:
- PROC_CTRL_IRQ_EN defined:
  - Adds output irq (1 bit).
  - irq is set on frame_done and stays high until software writes 1 to STATUS[31].
  - If set and clear occur in the same cycle, set wins.
  - irq resets to 0.
  - STATUS[31] reads irq.
- Undefined: no irq port, and STATUS[31] reads 0.

Test Plan:
- Reset, then read addresses 0–2 → 0x000F0005, 0x00C81428, 0x00000001; active outputs hue 5/15, sat 40, val 20/200.
- Write HUE = 0x001E000A with no commit, stream 2 frames → hue_lo/hue_hi stay 5/15. Set CTRL = 0x3 → at the next video sop hue becomes 10/30 and CTRL reads 0x1.
- 640x480 frame with red_sector high for delayed coords x = 100..109, y = 50..54 → frame_done pulse; BBOX_MIN = 0x00320064, BBOX_MAX = 0x0036006D, PIXCOUNT = 50, frame_count = 1.
- Frame with red_sector always 0 → BBOX_MIN = 0x07FF07FF, BBOX_MAX = 0, PIXCOUNT = 0.
- Video sop at y = 200 mid-frame, then a full frame with a single red pixel at (3,4) → exactly one frame_done; BBOX_MIN = BBOX_MAX = 0x00040003, PIXCOUNT = 1.
- Assert reset_n low during ACTIVE for 1 cycle, then stream a full frame without sop → no frame_done, frame_count = 0. With PROC_CTRL_IRQ_EN defined, run a normal frame → irq = 1; write STATUS[31] → irq = 0.
